sel_serializer: RTL and testbench
=================================

# sel_serializer

Parallel-to-serial front end for the serial pattern stage: accepts DATA_W-bit words over a valid/ready handshake and drives them one bit per clock onto `sel`, which the downstream stage samples on every rising clock edge. The block replaces ad-hoc bench tasks that drive `sel`. It also gives the RTL a single synthesizable source of serial stimulus, with a bit-valid qualifier and an end-of-word marker.

## Interface
Parameters:
- `DATA_W`, default 8: word width in bits. Legal range is 2..32.
- `MSB_FIRST`, default 1: 1 shifts out bit DATA_W-1 first; 0 shifts out bit 0 first.
- `GAP`, default 0: number of idle cycles inserted after each word. Legal range is 0..15.

Ports:
- `clk` in, 1: single clock. All logic updates on its rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `in_valid` in, 1: `in_data` holds a word to send.
- `in_ready` out, 1: block accepts a word this cycle.
- `in_data` in, DATA_W: word to serialize.
- `sel` out, 1: serial bit, registered.
- `sel_valid` out, 1: `sel` carries a live bit this cycle, registered.
- `word_done` out, 1: one-cycle pulse coincident with the last bit of a word, registered.
- `busy` out, 1: state is not IDLE.

## Operation
- States and transitions:
  - IDLE goes to SHIFT on accept.
  - SHIFT goes to PARITY, GAP_WAIT, SHIFT (back-to-back accept) or IDLE after its last data bit.
  - PARITY goes to GAP_WAIT, SHIFT or IDLE.
  - GAP_WAIT goes to IDLE when its counter expires.
- Accept: `in_valid && in_ready` at a rising edge. The word is captured into the shift register, the bit counter is loaded to 0 and the state becomes SHIFT.
- SHIFT: each cycle drives one bit on `sel` with `sel_valid`=1.
  - The bit counter, $clog2(DATA_W) bits wide, increments and ends at DATA_W-1.
  - Bit order is set by MSB_FIRST.
- `in_ready` is combinational from state:
  - 1 in IDLE.
  - 1 during the final bit cycle of a word when GAP=0. This allows back-to-back words with no bubble.
  - 0 otherwise, and forced 0 while `rst` is high.
- GAP_WAIT: held for exactly GAP cycles with `sel`=0, `sel_valid`=0, `in_ready`=0. When GAP=0 this state is skipped.
- Idle outputs: `sel`=0, `sel_valid`=0, `word_done`=0.
- `in_data` is sampled only at accept. Changes at other times are ignored.
- `in_valid` may drop without a transfer. Nothing happens in that case.

## Timing
- Reset values, applied immediately on `rst` assertion: state IDLE, `sel`=0, `sel_valid`=0, `word_done`=0, `busy`=0, counters 0.
- Latency: for a word accepted at edge k, bit 0 of the serial stream appears after edge k, in cycle k+1. The last data bit is in cycle k+DATA_W.
- `word_done`=1 in the cycle of the final serial bit: the last data bit, or the parity bit if enabled.
- Back-to-back with GAP=0: the next word's first bit follows the previous word's last bit in the very next cycle. `sel_valid` stays continuously 1.
- Word period is DATA_W (+1 with parity) + GAP cycles.
- Reset mid-word: the word is discarded with no `word_done`. After `rst` falls, `in_ready`=1 in the first cycle.

## Configuration
- Macro `SEL_SER_PARITY_EN`.
- Defined: the PARITY state is added. After the data bits, one even-parity bit (XOR of all data bits) is driven with `sel_valid`=1. The word length becomes DATA_W+1 cycles, and the back-to-back `in_ready` window moves to the parity cycle.
- Undefined: there is no PARITY state or logic, and a word is exactly DATA_W cycles.

## Test plan
- Reset: assert `rst` for 3 cycles mid-idle -> `sel`=0, `sel_valid`=0, `word_done`=0, `busy`=0, `in_ready`=0 during reset and 1 after.
- Single word: 8'hB4 with MSB_FIRST=1, accepted at edge k -> `sel` = 1,0,1,1,0,1,0,0 in cycles k+1..k+8, `word_done` only in k+8, then IDLE.
- Back-to-back: GAP=0, words 8'hFF then 8'h00 with `in_valid` held -> 16 consecutive `sel_valid` cycles, `sel` = eight 1s then eight 0s, two `word_done` pulses 8 cycles apart.
- Gap and LSB order: GAP=2, MSB_FIRST=0, word 8'h01 -> `sel` = 1 then seven 0s, then 2 cycles with `sel_valid`=0 and `in_ready`=0, then `in_ready`=1.
- Reset mid-word: assert `rst` after the 3rd bit of 8'hAA -> outputs reset immediately, no `word_done`. A subsequent word 8'h80 serializes correctly from its first bit.
- Parity (with SEL_SER_PARITY_EN): 8'hB4 -> 9th bit 0; 8'h07 -> 9th bit 1; `word_done` on the 9th bit.

Source files
------------

// File: rtl/sel_serializer.sv
// sel_serializer: valid/ready word input, one bit per clock on sel with
// sel_valid qualifier and word_done marker on the final serial bit.
// Optional feature macro: SEL_SER_PARITY_EN appends an even-parity bit per word.
module sel_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned GAP       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sel,
    output logic              sel_valid,
    output logic              word_done,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT    = 2'd1;
    localparam logic [1:0] GAP_WAIT = 2'd2;
`ifdef SEL_SER_PARITY_EN
    localparam logic [1:0] PARITY   = 2'd3;
`endif

    logic [1:0]        state, state_d;
    logic [DATA_W-1:0] sr, sr_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [3:0]        gap_cnt, gap_d;
    logic              sel_d, sel_valid_d, word_done_d;
    logic              last_bit, final_cycle, accept, load;
`ifdef SEL_SER_PARITY_EN
    logic              par, par_d;
`endif

    // Bit that goes on the wire next from a (partially shifted) word
    function automatic logic head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    // Word with the head bit consumed
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign last_bit = (state == SHIFT) && (cnt == CNT_W'(DATA_W - 1));
`ifdef SEL_SER_PARITY_EN
    assign final_cycle = (state == PARITY);
`else
    assign final_cycle = last_bit;
`endif

    // Ready in idle, or on the final serial bit when no gap follows
    assign in_ready = !rst && ((state == IDLE) || ((GAP == 0) && final_cycle));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        sr_d        = sr;
        cnt_d       = cnt;
        gap_d       = gap_cnt;
        sel_d       = 1'b0;
        sel_valid_d = 1'b0;
        word_done_d = 1'b0;
        load        = 1'b0;
`ifdef SEL_SER_PARITY_EN
        par_d       = par;
`endif
        case (state)
            IDLE: load = accept;
            SHIFT: begin
                if (!last_bit) begin
                    sel_d       = head(sr);
                    sel_valid_d = 1'b1;
                    sr_d        = advance(sr);
                    cnt_d       = CNT_W'(cnt + 1'b1);
`ifndef SEL_SER_PARITY_EN
                    word_done_d = (cnt == CNT_W'(DATA_W - 2));
`endif
                end else begin
`ifdef SEL_SER_PARITY_EN
                    state_d     = PARITY;
                    sel_d       = par;
                    sel_valid_d = 1'b1;
                    word_done_d = 1'b1;
`else
                    if (GAP != 0) begin
                        state_d = GAP_WAIT;
                        gap_d   = 4'd0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SEL_SER_PARITY_EN
            PARITY: begin
                if (GAP != 0) begin
                    state_d = GAP_WAIT;
                    gap_d   = 4'd0;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            GAP_WAIT: begin
                if (gap_cnt == 4'(GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = 4'(gap_cnt + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            sel_d       = head(in_data);
            sel_valid_d = 1'b1;
            sr_d        = advance(in_data);
`ifdef SEL_SER_PARITY_EN
            par_d       = ^in_data;
`endif
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            sel       <= 1'b0;
            sel_valid <= 1'b0;
            word_done <= 1'b0;
`ifdef SEL_SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            sr        <= sr_d;
            cnt       <= cnt_d;
            gap_cnt   <= gap_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            word_done <= word_done_d;
`ifdef SEL_SER_PARITY_EN
            par       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_sel_serializer.sv
// Bench for sel_serializer: two instances (MSB-first/no gap, LSB-first/gap 2)
// share the input stream and are checked every cycle against a timing model.
module tb_sel_serializer;

`ifdef SEL_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = 8 + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       rdy [2];
    logic       sel [2];
    logic       sv  [2];
    logic       wd  [2];
    logic       bsy [2];

    sel_serializer u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .sel(sel[0]), .sel_valid(sv[0]),
        .word_done(wd[0]), .busy(bsy[0])
    );

    sel_serializer #(.DATA_W(8), .MSB_FIRST(0), .GAP(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .sel(sel[1]), .sel_valid(sv[1]),
        .word_done(wd[1]), .busy(bsy[1])
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: edge count, and per instance the edge at which the live word was accepted
    int         e = 0;
    bit         act  [2];
    int         ea   [2];
    logic [7:0] w    [2];
    int         gapv [2] = '{0, 2};
    bit         msbv [2] = '{1'b1, 1'b0};
    logic [15:0] cap;

    function automatic logic m_ready(int u);
        return !rst && (!act[u] || (e >= ea[u] + L + gapv[u]) ||
                        (gapv[u] == 0 && e == ea[u] + L - 1));
    endfunction

    task automatic chk(string tag, int u, logic [15:0] obs, logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%h expected=%h edge=%0d", tag, u, obs, expv, e);
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 2; u++) begin
            int   i;
            logic live, b;
            i    = e - ea[u];
            live = act[u] && i >= 0 && i < L;
            if (i >= 0 && i < 8) b = msbv[u] ? w[u][7-i] : w[u][i];
            else                 b = ^w[u];
            chk("sel",       u, 16'(sel[u]), 16'(live ? b : 1'b0));
            chk("sel_valid", u, 16'(sv[u]),  16'(live));
            chk("word_done", u, 16'(wd[u]),  16'(live && i == L - 1));
            chk("busy",      u, 16'(bsy[u]), 16'(act[u] && i >= 0 && i < L + gapv[u]));
            chk("in_ready",  u, 16'(rdy[u]), 16'(m_ready(u)));
        end
    endtask

    // One clock: drive inputs, update model at the edge, check at the falling edge
    task automatic tick(input logic v, input logic [7:0] d);
        bit acc [2];
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        for (int u = 0; u < 2; u++) acc[u] = v && m_ready(u);
        e++;
        for (int u = 0; u < 2; u++) if (acc[u]) begin
            act[u] = 1'b1;
            ea[u]  = e;
            w[u]   = d;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic rst_pulse(int n);
        rst = 1'b1;
        act = '{1'b0, 1'b0};
        #1 check_all();
        repeat (n) tick(1'b1, 8'($urandom));
        rst = 1'b0;
        #1 check_all();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        act      = '{1'b0, 1'b0};
        ea       = '{0, 0};
        w        = '{8'h00, 8'h00};
        @(negedge clk);
        check_all();
        tick(1'b0, 8'h00);
        rst = 1'b0;
        #1 check_all();

        // Reset while idle
        tick(1'b0, 8'h00);
        rst_pulse(3);

        // Single word B4, captured bit string compared to the word
        cap = '0;
        tick(1'b1, 8'hB4);
        if (sv[0]) cap = {cap[14:0], sel[0]};
        repeat (L + 3) begin
            tick(1'b0, 8'($urandom));
            if (sv[0]) cap = {cap[14:0], sel[0]};
        end
        chk("b4_stream", 0, cap >> PAR, 16'h00B4);

        // Back-to-back FF then 00 with valid held
        tick(1'b1, 8'hFF);
        repeat (L) tick(1'b1, 8'h00);
        repeat (L + 4) tick(1'b0, 8'($urandom));

        // Single low bit word, exercises LSB order and gap on u1
        tick(1'b1, 8'h01);
        repeat (L + 4) tick(1'b0, 8'($urandom));

        // Reset after third bit of AA, then a clean 80
        tick(1'b1, 8'hAA);
        repeat (2) tick(1'b0, 8'($urandom));
        rst_pulse(1);
        tick(1'b1, 8'h80);
        repeat (L + 4) tick(1'b0, 8'($urandom));

        // Odd-parity-content word
        tick(1'b1, 8'h07);
        repeat (L + 4) tick(1'b0, 8'($urandom));

        // Random traffic with occasional resets
        repeat (600) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom));
            if ($urandom_range(0, 99) == 0) rst_pulse(1);
        end
        repeat (L + 4) tick(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
